vga_reg_capture: RTL and testbench



---
 rtl/vga_reg_capture.sv | 174 +++++++++++++++++
 tb/tb_vga_reg_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_reg_capture.sv
// Recovers an NBITS-wide value drawn as a row of on/off pixel cells in the RGB pixel stream.
// Optional build macro VGA_REG_CAPTURE_MARK_EN inverts the RGB of every sampled pixel on the output.
module vga_reg_capture #(
    parameter int         NBITS      = 16,
    parameter int         BIT_W      = 4,      // cell width in pixels, even and >= 2
    parameter logic [2:0] COLOR_MASK = 3'b111  // {B,G,R} channels that count as "on"
) (
    input  logic             px_clk,
    input  logic             rst_n,
    input  logic [25:0]      strRGB_i,
    output logic [25:0]      strRGB_o,
    input  logic             en_i,
    input  logic [9:0]       x_pos,
    input  logic [9:0]       y_pos,
    output logic [NBITS-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int IDX_W = $clog2(NBITS + 1);

    // Stream field views
    logic       px_active;
    logic       px_vs;
    logic [9:0] px_yc;
    logic [9:0] px_xc;
    logic [2:0] px_rgb;

    assign px_active = strRGB_i[0];
    assign px_vs     = strRGB_i[1];
    assign px_yc     = strRGB_i[12:3];
    assign px_xc     = strRGB_i[22:13];
    assign px_rgb    = strRGB_i[25:23];

    // Per-channel masking of the pixel colour
    logic [2:0] rgb_masked;
    logic       pixel_on;

    for (genvar gi = 0; gi < 3; gi++) begin : g_mask
        assign rgb_masked[gi] = px_rgb[gi] & COLOR_MASK[gi];
    end
    assign pixel_on = |rgb_masked;

    logic [1:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [NBITS-1:0] shift_reg, shift_next;
    logic [10:0]      tgt_reg, tgt_next;
    logic [9:0]       yl_reg, yl_next;
    logic             vs_reg;
    logic [25:0]      str_reg, str_next;
    logic [NBITS-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ovr_reg, ovr_next;

    logic fs;
    logic hit;

    assign fs = px_vs & ~vs_reg;

    // The target advances one cell per hit instead of being recomputed from
    // the index; bit 10 marks a cell that wrapped past 1023 and can never hit.
    assign hit = (state_reg == ST_ARMED) && !fs && px_active &&
                 (px_yc == yl_reg) && !tgt_reg[10] && (px_xc == tgt_reg[9:0]);

`ifdef VGA_REG_CAPTURE_MARK_EN
    assign str_next = hit ? {~strRGB_i[25:23], strRGB_i[22:0]} : strRGB_i;
`else
    assign str_next = strRGB_i;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tgt_next   = tgt_reg;
        yl_next    = yl_reg;

        if (fs) begin
            tgt_next = {1'b0, x_pos} + 11'(BIT_W / 2);
            yl_next  = y_pos;
        end

        case (state_reg)
            ST_IDLE: begin
                if (fs && en_i) begin
                    idx_next   = '0;
                    shift_next = '0;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fs) begin
                    idx_next   = '0;
                    shift_next = '0;
                    if (!en_i) begin
                        state_next = ST_IDLE;
                    end
                end else if (hit) begin
                    shift_next = {shift_reg[NBITS-2:0], pixel_on};
                    idx_next   = idx_reg + IDX_W'(1);
                    tgt_next   = tgt_reg + 11'(BIT_W);
                    if (idx_reg == IDX_W'(NBITS - 1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A fresh capture always wins over a simultaneous transfer
    always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        ovr_next   = ovr_reg;

        if (valid_reg && ready_i) begin
            valid_next = 1'b0;
            ovr_next   = 1'b0;
        end

        if (state_reg == ST_DONE) begin
            if (!valid_reg || ready_i) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
                ovr_next   = 1'b0;
            end else begin
                ovr_next = 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            shift_reg <= '0;
            tgt_reg   <= '0;
            yl_reg    <= '0;
            vs_reg    <= 1'b0;
            str_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tgt_reg   <= tgt_next;
            yl_reg    <= yl_next;
            vs_reg    <= px_vs;
            str_reg   <= str_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign strRGB_o  = str_reg;
    assign data_o    = data_reg;
    assign valid_o   = valid_reg;
    assign overrun_o = ovr_reg;

endmodule

// File: tb/tb_vga_reg_capture.sv
// Self-checking bench for vga_reg_capture: directed frames plus a per-cycle frame-level model.
module tb_vga_reg_capture;

    localparam logic [2:0] MASK = 3'b101;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic [25:0] strRGB_i;
    logic [25:0] strRGB_o;
    logic        en_i;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;

    always #5 px_clk = ~px_clk;

    vga_reg_capture #(
        .NBITS(16),
        .BIT_W(4),
        .COLOR_MASK(MASK)
    ) dut (
        .px_clk   (px_clk),
        .rst_n    (rst_n),
        .strRGB_i (strRGB_i),
        .strRGB_o (strRGB_o),
        .en_i     (en_i),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit          m_vs_prev;
    bit          m_armed;
    bit          m_done;
    int          m_xl;
    int          m_yl;
    int          m_n;
    logic [15:0] m_val;
    logic [15:0] e_data;
    bit          e_valid;
    bit          e_ovr;
    logic [25:0] e_str;

    task automatic model_reset();
        m_vs_prev = 0; m_armed = 0; m_done = 0;
        m_xl = 0; m_yl = 0; m_n = 0; m_val = '0;
        e_data = '0; e_valid = 0; e_ovr = 0; e_str = '0;
    endtask

    task automatic model_step();
        logic [25:0] s;
        bit          vs, fs, hitp, bitv, xfer;
        int          xc, yc, tgt;
        s    = strRGB_i;
        vs   = s[1];
        fs   = vs && !m_vs_prev;
        xc   = int'(s[22:13]);
        yc   = int'(s[12:3]);
        tgt  = m_xl + m_n * 4 + 2;
        hitp = m_armed && !fs && s[0] && (yc == m_yl) && (tgt < 1024) && (xc == tgt);
        bitv = (s[25:23] & MASK) != 3'b000;

        e_str = s;
`ifdef VGA_REG_CAPTURE_MARK_EN
        if (hitp) e_str[25:23] = ~s[25:23];
`endif

        xfer = e_valid && ready_i;
        if (m_done) begin
            if (!e_valid || xfer) begin
                e_data = m_val; e_valid = 1; e_ovr = 0;
            end else begin
                e_ovr = 1;
            end
        end else if (xfer) begin
            e_valid = 0; e_ovr = 0;
        end

        if (m_done) begin
            m_done = 0;
        end else if (fs) begin
            m_armed = en_i;
            m_n     = 0;
            m_val   = '0;
        end else if (hitp) begin
            m_val = m_val * 2 + 16'(bitv);
            m_n++;
            if (m_n == 16) begin
                m_done  = 1;
                m_armed = 0;
            end
        end

        if (fs) begin
            m_xl = int'(x_pos);
            m_yl = int'(y_pos);
        end
        m_vs_prev = vs;
    endtask

    always @(negedge px_clk) begin
        if (!rst_n) model_reset();
        check("strRGB_o", 32'(strRGB_o), 32'(e_str));
        check("data_o", 32'(data_o), 32'(e_data));
        check("valid_o", 32'(valid_o), 32'(e_valid));
        check("overrun_o", 32'(overrun_o), 32'(e_ovr));
        if (rst_n) model_step();
    end

    // ---------------- stimulus ----------------
    function automatic logic [25:0] pix(input bit act, input bit vs, input int yc, input int xc,
                                        input logic [2:0] rgb);
        logic [9:0] x10, y10;
        x10 = 10'(xc);
        y10 = 10'(yc);
        return {rgb, x10, y10, 1'b0, vs, act};
    endfunction

    task automatic cyc(input logic [25:0] s);
        @(posedge px_clk);
        #1;
        strRGB_i = s;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, 32'(data_o), 32'h0);
        check({tag, "_valid"}, 32'(valid_o), 32'h0);
        check({tag, "_overrun"}, 32'(overrun_o), 32'h0);
        check({tag, "_str"}, 32'(strRGB_o), 32'h0);
    endtask

    // Draws a short frame: VS pulse, then lines ys-1..ys+1; the cells sit on line ys.
    task automatic send_frame(input logic [15:0] pat, input logic [2:0] on_rgb, input int xs,
                              input int ys, input int width, input int rst_at);
        logic [2:0] rgb;
        int         k;
        repeat (2) cyc(pix(0, 1, 0, 0, 3'b000));
        for (int ly = ys - 1; ly <= ys + 1; ly++) begin
            for (int xc = 0; xc < width; xc++) begin
                rgb = 3'b000;
                if (ly == ys && xc >= xs && xc < xs + 64) begin
                    k = (xc - xs) / 4;
                    if (pat[15-k]) rgb = on_rgb;
                end
                cyc(pix(1, 0, ly, xc, rgb));
                if (rst_at >= 0 && ly == ys && xc == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_zero_outputs("rst_mid");
                end
            end
            cyc(pix(0, 0, ly, 0, 3'b000));
        end
        if (!rst_n) begin
            cyc(pix(0, 0, 0, 0, 3'b000));
            rst_n = 1'b1;
        end
        repeat (4) cyc(pix(0, 0, 0, 0, 3'b000));
        #1;
        frame_no++;
        $display("frame %0d: pattern %h rgb %b at x=%0d -> data_o %h valid_o %b overrun_o %b",
                 frame_no, pat, on_rgb, xs, data_o, valid_o, overrun_o);
    endtask

    task automatic pulse_ready();
        @(posedge px_clk); #1; ready_i = 1'b1;
        @(posedge px_clk); #1; ready_i = 1'b0;
        #1;
        check("ready_valid_clr", 32'(valid_o), 32'h0);
        check("ready_ovr_clr", 32'(overrun_o), 32'h0);
    endtask

    task automatic expect_capture(input string tag, input logic [15:0] val, input bit ovr);
        check({tag, "_valid"}, 32'(valid_o), 32'h1);
        check({tag, "_data"}, 32'(data_o), 32'(val));
        check({tag, "_overrun"}, 32'(overrun_o), 32'(ovr));
    endtask

    initial begin
        rst_n    = 1'b0;
        strRGB_i = '0;
        en_i     = 1'b0;
        x_pos    = '0;
        y_pos    = '0;
        ready_i  = 1'b0;
        repeat (3) @(posedge px_clk);
        #2;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        en_i  = 1'b1;
        x_pos = 10'd100;
        y_pos = 10'd50;

        send_frame(16'hA5C3, 3'b001, 100, 50, 200, -1);
        expect_capture("a5c3", 16'hA5C3, 1'b0);
        pulse_ready();

        send_frame(16'h1234, 3'b001, 100, 50, 200, -1);
        send_frame(16'hFFFF, 3'b001, 100, 50, 200, -1);
        expect_capture("overrun", 16'h1234, 1'b1);
        pulse_ready();

        // G-only hits are masked out, R hits count
        send_frame(16'hFFFF, 3'b010, 100, 50, 200, -1);
        expect_capture("mask_g", 16'h0000, 1'b0);
        pulse_ready();
        send_frame(16'hFFFF, 3'b001, 100, 50, 200, -1);
        expect_capture("mask_r", 16'hFFFF, 1'b0);

        // Reset after 8 bits, with a pending capture still held
        send_frame(16'h5A5A, 3'b100, 100, 50, 200, 131);
        check("post_rst_valid", 32'(valid_o), 32'h0);
        send_frame(16'h5A5A, 3'b100, 100, 50, 200, -1);
        expect_capture("after_rst", 16'h5A5A, 1'b0);
        pulse_ready();

        // Cells wrapping past 1023 abort every frame
        x_pos = 10'd1000;
        for (int f = 0; f < 3; f++) begin
            send_frame(16'hFFFF, 3'b001, 1000, 50, 1024, -1);
            check("wrap_no_valid", 32'(valid_o), 32'h0);
        end
        x_pos = 10'd100;

        // Consumer always ready: the capture is taken on the cycle it appears
        ready_i = 1'b1;
        send_frame(16'h0F0F, 3'b101, 100, 50, 200, -1);
        check("ready_hi_valid", 32'(valid_o), 32'h0);
        ready_i = 1'b0;

        // Disabled: the next frame is not captured
        en_i = 1'b0;
        send_frame(16'hC3C3, 3'b001, 100, 50, 200, -1);
        send_frame(16'hC3C3, 3'b001, 100, 50, 200, -1);
        check("disabled_valid", 32'(valid_o), 32'h0);

        repeat (3) @(posedge px_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
